// File: rtl/move_scheduler.sv
// move_scheduler: walks a loaded move list, requests each post-move grid,
// scores it through the evaluator and keeps the best-scoring move.
module move_scheduler #(
   parameter int MAX_MOVES   = 220,
   parameter int SCORE_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          moves_iv,
   input  logic [7:0]                    total_move_id,
   output logic [7:0]                    move_num,
   output logic                          compute_grid,
   input  logic                          grid_iv,
   output logic                          eval_ov,
   input  logic                          eval_ready,
   input  logic                          score_iv,
   input  logic signed [SCORE_WIDTH-1:0] score_id,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done_ov,
   output logic                          best_valid,
   output logic [7:0]                    best_move,
   output logic signed [SCORE_WIDTH-1:0] best_score
);

   typedef enum logic [2:0] {
      IDLE, REQ, WAIT_GRID, ISSUE, WAIT_SCORE, UPDATE, DONE
   } state_t;

   localparam logic [7:0] MAX_N    = 8'(MAX_MOVES);
   localparam logic [7:0] GRID_TMO = 8'd254;

   state_t state, state_nxt;

   logic [7:0]                    n_q;
   logic [7:0]                    n_in;
   logic [7:0]                    grid_tmr;
   logic signed [SCORE_WIDTH-1:0] score_q;
   logic                          last_move;
   logic                          new_best;
   logic                          start;
   logic                          kill;
   logic                          cap;
   logic                          upd;

   assign n_in      = (total_move_id > MAX_N) ? MAX_N : total_move_id;
   assign last_move = (move_num == n_q - 8'd1);
   assign new_best  = !best_valid || (score_q > best_score);
   assign busy      = (state != IDLE);
   assign kill      = abort && busy;
   assign start     = (state == IDLE) && moves_iv && !abort;
   assign cap       = (state == WAIT_SCORE) && score_iv && !abort;
   assign upd       = (state == UPDATE) && !abort;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      compute_grid = 1'b0;
      eval_ov      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = (n_in == 8'd0) ? DONE : REQ;
         end
         REQ: begin
            compute_grid = !abort;
            state_nxt    = WAIT_GRID;
         end
         WAIT_GRID: begin
            // a lost grid response is retried by re-requesting it
            if (grid_iv)                  state_nxt = ISSUE;
            else if (grid_tmr == GRID_TMO) state_nxt = REQ;
         end
         ISSUE: begin
            eval_ov = !abort;
            if (eval_ready) state_nxt = WAIT_SCORE;
         end
         WAIT_SCORE: begin
            if (score_iv) state_nxt = UPDATE;
         end
         UPDATE: begin
            state_nxt = last_move ? DONE : REQ;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (kill) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q        <= '0;
         move_num   <= '0;
         grid_tmr   <= '0;
         score_q    <= '0;
         done_ov    <= 1'b0;
         best_valid <= 1'b0;
         best_move  <= '0;
         best_score <= '0;
      end else begin
         done_ov  <= (state == DONE) && !abort;
         grid_tmr <= (state == WAIT_GRID) ? grid_tmr + 8'd1 : 8'd0;
         unique case (1'b1)
            kill: begin
               best_valid <= 1'b0;
            end
            start: begin
               n_q        <= n_in;
               move_num   <= '0;
               best_valid <= 1'b0;
            end
            cap: begin
               score_q <= score_id;
            end
            upd: begin
               // strict compare keeps the lower index on ties
               if (new_best) begin
                  best_valid <= 1'b1;
                  best_score <= score_q;
                  best_move  <= move_num;
               end
               if (!last_move) move_num <= move_num + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed and randomized searches checked against
// a first-maximum / cycle-sum model of the scheduler.
module tb_move_scheduler;

   localparam int MAXM = 220;
   localparam int SW   = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 moves_iv = 1'b0;
   logic [7:0]           total_move_id = '0;
   logic [7:0]           move_num;
   logic                 compute_grid;
   logic                 grid_iv = 1'b0;
   logic                 eval_ov;
   logic                 eval_ready = 1'b0;
   logic                 score_iv = 1'b0;
   logic signed [SW-1:0] score_id = '0;
   logic                 abort = 1'b0;
   logic                 busy;
   logic                 done_ov;
   logic                 best_valid;
   logic [7:0]           best_move;
   logic signed [SW-1:0] best_score;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int cg_cnt = 0;
   int sc [256];
   int gd [256];
   int rd [256];
   int sd [256];

   always #5 clk = ~clk;

   always @(negedge clk) if (compute_grid) cg_cnt++;

   move_scheduler #(.MAX_MOVES(MAXM), .SCORE_WIDTH(SW)) dut (
      .clk(clk), .rst(rst),
      .moves_iv(moves_iv), .total_move_id(total_move_id),
      .move_num(move_num), .compute_grid(compute_grid),
      .grid_iv(grid_iv), .eval_ov(eval_ov),
      .eval_ready(eval_ready), .score_iv(score_iv),
      .score_id(score_id), .abort(abort), .busy(busy),
      .done_ov(done_ov), .best_valid(best_valid),
      .best_move(best_move), .best_score(best_score)
   );

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic serve_move(input int idx, input int s, input int g,
                             input int r, input int d, input bit poke,
                             output int re_at, output int re_cnt);
      int t0;
      int k;
      re_at  = -1;
      re_cnt = 0;
      k = 0;
      while (!compute_grid && k < 20) begin tick(); k++; end
      chk("req_seen", compute_grid, 1);
      chk("req_move_num", move_num, idx);
      t0 = cyc;
      if (poke) begin moves_iv = 1'b1; total_move_id = 8'd7; end
      tick();
      moves_iv = 1'b0;
      chk("cg_one_cycle", compute_grid, 0);
      for (int i = 0; i < g; i++) begin
         tick();
         if (compute_grid) begin
            re_cnt++;
            if (re_at < 0) re_at = cyc - t0;
         end
      end
      grid_iv = 1'b1; tick(); grid_iv = 1'b0;
      chk("issue_eval_ov", eval_ov, 1);
      for (int i = 0; i < r; i++) begin
         tick();
         chk("hold_eval_ov", eval_ov, 1);
         chk("hold_move_num", move_num, idx);
      end
      eval_ready = 1'b1; tick(); eval_ready = 1'b0;
      chk("eval_ov_drop", eval_ov, 0);
      for (int i = 0; i < d; i++) tick();
      score_iv = 1'b1; score_id = SW'(s); tick(); score_iv = 1'b0;
      chk("upd_move_num", move_num, idx);
      tick();
   endtask

   task automatic run_search(input int ntot, input bit poke);
      int n, bi, lat, c0, cg0, k, ra, rc, re_exp;
      n = (ntot > MAXM) ? MAXM : ntot;
      bi = 0;
      lat = 2;
      re_exp = 0;
      for (int i = 0; i < n; i++) begin
         lat += 5 + gd[i] + rd[i] + sd[i];
         if (sc[i] > sc[bi]) bi = i;
      end
      c0  = cyc;
      cg0 = cg_cnt;
      moves_iv = 1'b1; total_move_id = 8'(ntot); tick(); moves_iv = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_bv_clear", best_valid, 0);
      if (n == 0) chk("empty_no_req", compute_grid, 0);
      for (int i = 0; i < n; i++) begin
         serve_move(i, sc[i], gd[i], rd[i], sd[i], poke && i == 0, ra, rc);
         re_exp += (gd[i] + 1) / 256;
         chk("reissues", rc, (gd[i] + 1) / 256);
         if (gd[i] >= 255) chk("reissue_at", ra, 256);
      end
      k = 0;
      while (!done_ov && k < 20) begin tick(); k++; end
      chk("done_seen", done_ov, 1);
      chk("done_latency", cyc - c0, lat);
      chk("cg_pulses", cg_cnt - cg0, n + re_exp);
      chk("best_valid", best_valid, n > 0);
      if (n > 0) begin
         chk("best_move", best_move, bi);
         chk("best_score", best_score, sc[bi]);
         chk("last_move_num", move_num, n - 1);
      end
      tick();
      chk("done_one_cycle", done_ov, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ra, rc, nt;
      tick(); tick();
      chk("rst_move_num", move_num, 0);
      chk("rst_cg", compute_grid, 0);
      chk("rst_eval_ov", eval_ov, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_ov, 0);
      chk("rst_bv", best_valid, 0);
      chk("rst_bm", best_move, 0);
      chk("rst_bs", best_score, 0);
      rst = 1'b0;
      tick();

      // ties keep the earlier index; a mid-search moves_iv is ignored
      sc[0] = 5; sc[1] = -3; sc[2] = 5;
      for (int i = 0; i < 3; i++) begin gd[i] = 0; rd[i] = 0; sd[i] = 0; end
      run_search(3, 1'b1);

      // stray score and abort+moves_iv in idle change nothing
      score_iv = 1'b1; score_id = 16'sd99; tick(); score_iv = 1'b0;
      abort = 1'b1; moves_iv = 1'b1; total_move_id = 8'd4;
      tick();
      abort = 1'b0; moves_iv = 1'b0;
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_bv", best_valid, 1);
      chk("abort_idle_bs", best_score, 5);

      run_search(0, 1'b0);

      // evaluator stalls for 10 cycles
      sc[0] = -7; sc[1] = -2;
      gd[0] = 0; gd[1] = 0; rd[0] = 10; rd[1] = 0; sd[0] = 0; sd[1] = 0;
      run_search(2, 1'b0);

      // grid response withheld past the retry timeout
      sc[0] = 1; sc[1] = 3;
      gd[0] = 0; gd[1] = 300; rd[0] = 0; rd[1] = 0; sd[0] = 0; sd[1] = 0;
      run_search(2, 1'b0);

      for (int t = 0; t < 6; t++) begin
         nt = $urandom_range(1, 12);
         for (int i = 0; i < nt; i++) begin
            sc[i] = int'($urandom_range(0, 8)) - 4;
            gd[i] = $urandom_range(0, 3);
            rd[i] = $urandom_range(0, 3);
            sd[i] = $urandom_range(0, 3);
         end
         run_search(nt, 1'b0);
      end

      // oversized list clamps to MAX_MOVES
      for (int i = 0; i < MAXM; i++) begin
         sc[i] = int'($signed(16'($urandom)));
         gd[i] = 0; rd[i] = 0; sd[i] = 0;
      end
      run_search(250, 1'b0);

      // abort while waiting on the second score
      sc[0] = 2;
      moves_iv = 1'b1; total_move_id = 8'd3; tick(); moves_iv = 1'b0;
      serve_move(0, 2, 0, 0, 0, 1'b0, ra, rc);
      chk("pre_abort_bv", best_valid, 1);
      tick();
      grid_iv = 1'b1; tick(); grid_iv = 1'b0;
      eval_ready = 1'b1; tick(); eval_ready = 1'b0;
      chk("ws_busy", busy, 1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_bv", best_valid, 0);
      chk("abort_eval_ov", eval_ov, 0);
      chk("abort_cg", compute_grid, 0);
      score_iv = 1'b1; score_id = 16'sd77; tick(); score_iv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_done", done_ov, 0);
         tick();
      end
      sc[0] = -1; sc[1] = 4;
      for (int i = 0; i < 2; i++) begin gd[i] = 1; rd[i] = 0; sd[i] = 2; end
      run_search(2, 1'b0);

      // reset mid-search discards progress
      moves_iv = 1'b1; total_move_id = 8'd3; tick(); moves_iv = 1'b0;
      serve_move(0, 9, 0, 0, 0, 1'b0, ra, rc);
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_bv", best_valid, 0);
      chk("mid_rst_bs", best_score, 0);
      chk("mid_rst_mn", move_num, 0);
      grid_iv = 1'b1; tick(); grid_iv = 1'b0;
      score_iv = 1'b1; tick(); score_iv = 1'b0;
      chk("mid_rst_eval_ov", eval_ov, 0);
      chk("mid_rst_busy2", busy, 0);
      chk("mid_rst_bv2", best_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
